// File: rtl/elixirchip_es1_spu_match_arbiter_if.sv
// ----------------------------------------------------------------------------
// elixirchip_es1_spu_match_arbiter_if
// Request/result bundle between the SPU issue ports and the shared compare
// arbiter.
//   s_valid  [NUM_REQ]            request pending, one bit per requester
//   s_ready  [NUM_REQ]            request accepted this cycle (one-hot or zero)
//   s_data0  [NUM_REQ*DATA_BITS]  operand 0, requester i at [i*DATA_BITS +: DATA_BITS]
//   s_data1  [NUM_REQ*DATA_BITS]  operand 1, same slicing
//   s_clear  [NUM_REQ]            force the result to CLEAR_DATA
//   m_valid                       result valid
//   m_id     [ID_BITS]            requester owning the result
//   m_data                        1 when data0 == data1
// master: requester side. slave: arbiter side.
// ----------------------------------------------------------------------------
interface elixirchip_es1_spu_match_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_BITS   = $clog2(NUM_REQ),
  parameter int unsigned DATA_BITS = 8
);
  logic [NUM_REQ-1:0]           s_valid;
  logic [NUM_REQ-1:0]           s_ready;
  logic [NUM_REQ*DATA_BITS-1:0] s_data0;
  logic [NUM_REQ*DATA_BITS-1:0] s_data1;
  logic [NUM_REQ-1:0]           s_clear;
  logic                         m_valid;
  logic [ID_BITS-1:0]           m_id;
  logic                         m_data;

  modport master (
    output s_valid, s_data0, s_data1, s_clear,
    input  s_ready, m_valid, m_id, m_data
  );

  modport slave (
    input  s_valid, s_data0, s_data1, s_clear,
    output s_ready, m_valid, m_id, m_data
  );
endinterface

// File: rtl/elixirchip_es1_spu_match_arbiter.sv
// ----------------------------------------------------------------------------
// elixirchip_es1_spu_op_match
// Equality compare with a fixed pipeline: the compare of the registered
// operands is captured in stage 0 and then travels through LATENCY further
// stages. A clear forces the slot result to CLEAR_DATA.
//   reset        synchronous, active-high; pipeline held at CLEAR_DATA
//   clk          clock
//   cke          clock enable; 0 freezes the pipeline
//   s_data0_i    operand 0
//   s_data1_i    operand 1
//   s_clear_i    force result to CLEAR_DATA
//   m_data_o     result, LATENCY+1 enabled cycles after the operands
// ----------------------------------------------------------------------------
module elixirchip_es1_spu_op_match #(
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned DATA_BITS  = 8,
  parameter logic        CLEAR_DATA = 1'b1,
  parameter string       DEVICE     = "RTL",
  parameter string       SIMULATION = "false",
  parameter string       DEBUG      = "false"
) (
  input  logic                 reset,
  input  logic                 clk,
  input  logic                 cke,
  input  logic [DATA_BITS-1:0] s_data0_i,
  input  logic [DATA_BITS-1:0] s_data1_i,
  input  logic                 s_clear_i,
  output logic                 m_data_o
);

  localparam int unsigned STAGES = LATENCY + 1;

  logic              match_c;
  logic [STAGES-1:0] pipe_q;
  logic [STAGES-1:0] pipe_d;

  // Compare form: plain equality for generic RTL, xor-reduce for mapped targets.
  if (DEVICE == "RTL") begin : g_cmp_eq
    assign match_c = (s_data0_i == s_data1_i);
  end else begin : g_cmp_xor
    assign match_c = ~|(s_data0_i ^ s_data1_i);
  end

  // Result shift register; frozen while cke is low.
  always_comb begin
    pipe_d = pipe_q;
    if (cke) begin
      pipe_d[0] = s_clear_i ? CLEAR_DATA : match_c;
      for (int unsigned i = 1; i < STAGES; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= {STAGES{CLEAR_DATA}};
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign m_data_o = pipe_q[STAGES-1];

  // Debug builds trap unknown operands entering the compare.
  if (SIMULATION == "true" && DEBUG == "true") begin : g_dbg
    always_ff @(posedge clk) begin
      if (!reset && cke) begin
        assert (!$isunknown({s_clear_i, s_data0_i, s_data1_i}));
      end
    end
  end

endmodule

// ----------------------------------------------------------------------------
// elixirchip_es1_spu_match_arbiter
// Shares one op_match compare unit between NUM_REQ requesters. A round-robin
// arbiter accepts at most one request per enabled cycle, registers the
// winner's operands into op_match, and a tag pipeline aligned with the
// op_match latency routes each result back as (m_id, m_data).
//   reset   synchronous, active-high; drops all in-flight requests
//   clk     clock
//   cke     global clock enable; 0 freezes the whole block
//   bus     slave side of elixirchip_es1_spu_match_arbiter_if
// A grant on edge T is presented on the cycle after edge T+1+LATENCY.
// ----------------------------------------------------------------------------
module elixirchip_es1_spu_match_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_BITS    = $clog2(NUM_REQ),
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned DATA_BITS  = 8,
  parameter logic        CLEAR_DATA = 1'b1,
  parameter string       DEVICE     = "RTL",
  parameter string       SIMULATION = "false",
  parameter string       DEBUG      = "false"
) (
  input  logic reset,
  input  logic clk,
  input  logic cke,
  elixirchip_es1_spu_match_arbiter_if.slave bus
);

  localparam int unsigned STAGES = LATENCY + 1;

  // Arbitration
  logic [ID_BITS-1:0] ptr_q;
  logic [ID_BITS-1:0] ptr_d;
  logic               found_c;
  logic [ID_BITS-1:0] win_c;
  logic               grant_c;
  logic [NUM_REQ-1:0] s_ready_c;

  // Issue stage
  logic [DATA_BITS-1:0] iss_d0_q,  iss_d0_d;
  logic [DATA_BITS-1:0] iss_d1_q,  iss_d1_d;
  logic                 iss_clr_q, iss_clr_d;
  logic                 iss_vld_q, iss_vld_d;
  logic [ID_BITS-1:0]   iss_id_q,  iss_id_d;

  // Winner operand select
  logic [DATA_BITS-1:0] sel_d0_c;
  logic [DATA_BITS-1:0] sel_d1_c;
  logic                 sel_clr_c;

  // Tag pipeline, one stage per op_match result stage
  logic [STAGES-1:0]              tag_vld_q, tag_vld_d;
  logic [STAGES-1:0][ID_BITS-1:0] tag_id_q,  tag_id_d;

  logic match_data;

  // Round-robin search: start at ptr, go upward, wrap to 0.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    found_c = 1'b0;
    win_c   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!found_c && bus.s_valid[ID_BITS'(idx)]) begin
        found_c = 1'b1;
        win_c   = ID_BITS'(idx);
      end
    end
  end

  assign grant_c = cke & ~reset & found_c;

  // One-hot accept strobe back to the winner.
  always_comb begin
    s_ready_c = '0;
    if (grant_c) begin
      s_ready_c[win_c] = 1'b1;
    end
  end

  assign bus.s_ready = s_ready_c;

  // Constant-index mux of the winner's operands.
  always_comb begin
    sel_d0_c  = '0;
    sel_d1_c  = '0;
    sel_clr_c = 1'b0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (ID_BITS'(r) == win_c) begin
        sel_d0_c  = bus.s_data0[r*DATA_BITS +: DATA_BITS];
        sel_d1_c  = bus.s_data1[r*DATA_BITS +: DATA_BITS];
        sel_clr_c = bus.s_clear[r];
      end
    end
  end

  // Next-state for pointer, issue registers and tags; all hold when cke=0.
  always_comb begin
    ptr_d     = ptr_q;
    iss_d0_d  = iss_d0_q;
    iss_d1_d  = iss_d1_q;
    iss_clr_d = iss_clr_q;
    iss_vld_d = iss_vld_q;
    iss_id_d  = iss_id_q;
    tag_vld_d = tag_vld_q;
    tag_id_d  = tag_id_q;
    if (cke) begin
      iss_vld_d = grant_c;
      if (grant_c) begin
        ptr_d     = (win_c == ID_BITS'(NUM_REQ - 1)) ? '0 : win_c + ID_BITS'(1);
        iss_d0_d  = sel_d0_c;
        iss_d1_d  = sel_d1_c;
        iss_clr_d = sel_clr_c;
        iss_id_d  = win_c;
      end
      // Stage 0 lines up with the op_match compare register.
      tag_vld_d[0] = iss_vld_q;
      tag_id_d[0]  = iss_id_q;
      for (int unsigned i = 1; i < STAGES; i++) begin
        tag_vld_d[i] = tag_vld_q[i-1];
        tag_id_d[i]  = tag_id_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      iss_d0_q  <= '0;
      iss_d1_q  <= '0;
      iss_clr_q <= 1'b0;
      iss_vld_q <= 1'b0;
      iss_id_q  <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      iss_d0_q  <= iss_d0_d;
      iss_d1_q  <= iss_d1_d;
      iss_clr_q <= iss_clr_d;
      iss_vld_q <= iss_vld_d;
      iss_id_q  <= iss_id_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  // Shared compare resource; it also computes on idle slots, which the tag masks.
  elixirchip_es1_spu_op_match #(
    .LATENCY    (LATENCY),
    .DATA_BITS  (DATA_BITS),
    .CLEAR_DATA (CLEAR_DATA),
    .DEVICE     (DEVICE),
    .SIMULATION (SIMULATION),
    .DEBUG      (DEBUG)
  ) u_op_match (
    .reset     (reset),
    .clk       (clk),
    .cke       (cke),
    .s_data0_i (iss_d0_q),
    .s_data1_i (iss_d1_q),
    .s_clear_i (iss_clr_q),
    .m_data_o  (match_data)
  );

  // Reset also masks the output so a dropped request can never surface.
  assign bus.m_valid = tag_vld_q[STAGES-1] & cke & ~reset;
  assign bus.m_id    = tag_id_q[STAGES-1];
  assign bus.m_data  = match_data;

endmodule

// File: tb/tb_elixirchip_es1_spu_match_arbiter.sv
module tb_elixirchip_es1_spu_match_arbiter;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned ID_BITS   = 2;
  localparam int unsigned LATENCY   = 3;
  localparam int unsigned DATA_BITS = 8;

  typedef struct packed {
    logic [ID_BITS-1:0] id;
    logic               data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic cke;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   push_en  = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  elixirchip_es1_spu_match_arbiter_if #(
    .NUM_REQ   (NUM_REQ),
    .ID_BITS   (ID_BITS),
    .DATA_BITS (DATA_BITS)
  ) bus ();

  elixirchip_es1_spu_match_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ID_BITS    (ID_BITS),
    .LATENCY    (LATENCY),
    .DATA_BITS  (DATA_BITS),
    .CLEAR_DATA (1'b1),
    .DEVICE     ("RTL"),
    .SIMULATION ("false"),
    .DEBUG      ("false")
  ) dut (
    .reset (reset),
    .clk   (clk),
    .cke   (cke),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b, input logic c);
    bus.s_data0[r*DATA_BITS +: DATA_BITS] = a;
    bus.s_data1[r*DATA_BITS +: DATA_BITS] = b;
    bus.s_clear[r] = c;
  endtask

  // Expected result of the granted requester from the values the bench drives.
  task automatic push_exp(input logic [3:0] onehot);
    exp_t e;
    logic [7:0] a;
    logic [7:0] b;
    e = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (onehot[r]) begin
        a = bus.s_data0[r*DATA_BITS +: DATA_BITS];
        b = bus.s_data1[r*DATA_BITS +: DATA_BITS];
        e.id   = ID_BITS'(r);
        e.data = bus.s_clear[r] ? 1'b1 : (a == b);
      end
    end
    exp_q.push_back(e);
  endtask

  // One cycle: drive cke/s_valid, check s_ready mid-cycle, log the grant.
  task automatic drive(input logic c, input logic [3:0] v, input logic [3:0] exp_rdy);
    cke = c;
    bus.s_valid = v;
    @(negedge clk);
    check("s_ready", 32'(bus.s_ready), 32'(exp_rdy));
    if (!c || reset) check("m_valid_masked", 32'(bus.m_valid), 32'd0);
    if (exp_rdy != 4'b0000 && push_en) push_exp(exp_rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    cke = 1'b1;
    bus.s_valid = '0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: one pop per cycle that presents m_valid.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.m_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got id %0d data %0d, expected none (t=%0t)",
                   bus.m_id, bus.m_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("m_id", 32'(bus.m_id), 32'(mon_e.id));
          check("m_data", 32'(bus.m_data), 32'(mon_e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cke   = 1'b1;
    bus.s_valid = '0;
    bus.s_data0 = '0;
    bus.s_data1 = '0;
    bus.s_clear = '0;

    // Reset state: no accept even with every requester asking.
    drive(1'b1, 4'b1111, 4'b0000);
    drive(1'b1, 4'b1111, 4'b0000);
    check("rst_m_id", 32'(bus.m_id), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd1);
    reset   = 1'b0;
    push_en = 1'b1;

    // 1. Single requester and its latency; ptr 0 -> 2.
    set_req(1, 8'h80, 8'h80, 1'b0);
    drive(1'b1, 4'b0010, 4'b0010);
    bus.s_valid = '0;
    repeat (4) begin
      @(negedge clk);
      check("lat_m_valid_early", 32'(bus.m_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("lat_m_valid_due", 32'(bus.m_valid), 32'd1);
    @(posedge clk);
    #1;
    set_req(1, 8'hfe, 8'hff, 1'b0);
    drive(1'b1, 4'b0010, 4'b0010);
    drain();

    // 2. All four requesting, ptr starts at 2.
    for (int r = 0; r < NUM_REQ; r++) set_req(r, 8'(r), 8'(r), 1'b0);
    repeat (2) begin
      drive(1'b1, 4'b1111, 4'b0100);
      drive(1'b1, 4'b1111, 4'b1000);
      drive(1'b1, 4'b1111, 4'b0001);
      drive(1'b1, 4'b1111, 4'b0010);
    end
    drain();

    // 3. Move ptr to 1, then req0/req2 alternate with wrap-around.
    set_req(0, 8'h55, 8'h55, 1'b0);
    drive(1'b1, 4'b0001, 4'b0001);
    set_req(2, 8'h12, 8'h13, 1'b0);
    drive(1'b1, 4'b0101, 4'b0100);
    drive(1'b1, 4'b0101, 4'b0001);
    drive(1'b1, 4'b0101, 4'b0100);
    drive(1'b1, 4'b0101, 4'b0001);
    drain();

    // 4. Stall three cycles while the first result sits at the output.
    set_req(1, 8'h33, 8'h33, 1'b0);
    set_req(3, 8'h40, 8'h41, 1'b0);
    set_req(0, 8'ha5, 8'ha5, 1'b0);
    drive(1'b1, 4'b0010, 4'b0010);
    drive(1'b1, 4'b1000, 4'b1000);
    repeat (3) drive(1'b1, 4'b0000, 4'b0000);
    repeat (3) drive(1'b0, 4'b0001, 4'b0000);
    drive(1'b1, 4'b0001, 4'b0001);
    drain();

    // 5. Clear forces CLEAR_DATA on a mismatch; then the same pair uncleared.
    set_req(3, 8'h00, 8'hff, 1'b1);
    drive(1'b1, 4'b1000, 4'b1000);
    set_req(3, 8'h00, 8'hff, 1'b0);
    drive(1'b1, 4'b1000, 4'b1000);
    drain();

    // 6. Reset with three requests in flight; they must never appear.
    set_req(0, 8'h11, 8'h11, 1'b0);
    set_req(1, 8'h22, 8'h22, 1'b0);
    set_req(2, 8'h33, 8'h34, 1'b0);
    set_req(3, 8'h77, 8'h77, 1'b0);
    push_en = 1'b0;
    drive(1'b1, 4'b0111, 4'b0001);
    drive(1'b1, 4'b0110, 4'b0010);
    drive(1'b1, 4'b0100, 4'b0100);
    reset = 1'b1;
    drive(1'b1, 4'b1100, 4'b0000);
    drive(1'b1, 4'b1100, 4'b0000);
    check("rst2_m_data", 32'(bus.m_data), 32'd1);
    check("rst2_m_id", 32'(bus.m_id), 32'd0);
    reset   = 1'b0;
    push_en = 1'b1;
    drive(1'b1, 4'b1100, 4'b0100);
    drive(1'b1, 4'b1000, 4'b1000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
